count_event_logger: RTL and testbench

Downstream monitor for the 3-bit free-running counter stage. It samples the counter value on a strobe and classifies each sample against the previous one. Wrap-arounds (7→0) and illegal jumps become event records in a small FIFO, which a consumer drains over a valid/ready handshake. It gives the bench and any supervisor logic a lossless, timestamp-free trace of counter health.

---
 rtl/count_event_pkg.sv | 24 ++
 rtl/count_event_logger_if.sv | 13 +
 rtl/ev_fifo.sv | 75 +++++++
 rtl/count_event_logger.sv | 120 ++++++++++++
 tb/tb_count_event_logger.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/count_event_pkg.sv
// Shared types and record layout for the counter event logger.
package count_event_pkg;

    localparam int unsigned Q_W       = 3;
    localparam int unsigned EV_TYPE_W = 2;

    localparam logic [EV_TYPE_W-1:0] EV_WRAP = 2'b01;
    localparam logic [EV_TYPE_W-1:0] EV_JUMP = 2'b10;

    // Record layout, LSB first: {type, wraps, q}
    localparam int unsigned REC_Q_LSB     = 0;
    localparam int unsigned REC_WRAPS_LSB = Q_W;

    // Type field sits above the wrap counter, whose width is a block parameter
    function automatic int unsigned rec_type_lsb(input int unsigned wrap_w);
        return Q_W + wrap_w;
    endfunction

    typedef enum logic {
        INIT,
        TRACK
    } state_e;

endpackage

// File: rtl/count_event_logger_if.sv
// Valid/ready event record channel between the logger and its consumer.
interface count_event_logger_if #(
    parameter int unsigned DATA_W = 13
) ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/ev_fifo.sv
// Synchronous show-ahead FIFO with flush and occupancy output.
module ev_fifo #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     valid_o,
    output logic                     full_c,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             valid_q;
    logic             do_push;
    logic             do_pop;

    // A full FIFO still accepts a push when the head leaves in the same cycle
    always_comb begin
        full_c  = (level_q == LW'(DEPTH));
        do_pop  = pop_i && valid_q && !flush_i;
        do_push = push_i && !flush_i && (!full_c || do_pop);
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LW'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage, pointers and occupancy; flush empties without touching storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            valid_q <= (level_d != '0);
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = valid_q;
    assign level_o = level_q;

endmodule

// File: rtl/count_event_logger.sv
// Classifies strobed counter samples and queues WRAP/JUMP records.
module count_event_logger
    import count_event_pkg::*;
#(
    parameter int unsigned WRAP_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [Q_W-1:0]         q_in,
    input  logic                   q_en,
    input  logic                   clr,
    count_event_logger_if.master   ev,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
);

    localparam int unsigned REC_W    = EV_TYPE_W + WRAP_W + Q_W;
    localparam int unsigned TYPE_LSB = rec_type_lsb(WRAP_W);
    localparam logic [Q_W-1:0] Q_MAX = '1;

    state_e            state_q;
    state_e            state_d;
    logic [Q_W-1:0]    prev_q;
    logic [Q_W-1:0]    prev_d;
    logic [WRAP_W-1:0] wraps_q;
    logic [WRAP_W-1:0] wraps_d;
    logic              push_c;
    logic [REC_W-1:0]  rec_c;
    logic              pop_c;
    logic              full_c;
    logic              ovf_q;
    logic              is_hold_c;
    logic              is_step_c;
    logic              is_wrap_c;

    assign pop_c = ev.valid && ev.ready;

    // Sample classification against the previous value, mod-8
    always_comb begin
        is_hold_c = (q_in == prev_q);
        is_step_c = (prev_q != Q_MAX) && (q_in == Q_W'(prev_q + Q_W'(1)));
        is_wrap_c = (prev_q == Q_MAX) && (q_in == '0);
    end

    // Next-state, wrap counter and record build; clr overrides any sample
    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        wraps_d = wraps_q;
        push_c  = 1'b0;
        rec_c   = '0;
        if (clr) begin
            state_d = INIT;
            wraps_d = '0;
        end else if (q_en) begin
            prev_d = q_in;
            case (state_q)
                INIT: begin
                    state_d = TRACK;
                end
                TRACK: begin
                    if (is_wrap_c) begin
                        wraps_d = WRAP_W'(wraps_q + WRAP_W'(1));
                        push_c  = 1'b1;
                        rec_c[TYPE_LSB +: EV_TYPE_W] = EV_WRAP;
                    end else if (!is_hold_c && !is_step_c) begin
                        push_c  = 1'b1;
                        rec_c[TYPE_LSB +: EV_TYPE_W] = EV_JUMP;
                    end
                    rec_c[REC_WRAPS_LSB +: WRAP_W] = wraps_d;
                    rec_c[REC_Q_LSB +: Q_W]        = q_in;
                end
            endcase
        end
    end

    // FSM state, reference value and wrap counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
            prev_q  <= '0;
            wraps_q <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            wraps_q <= wraps_d;
        end
    end

    // Sticky overflow: a push refused by a full FIFO with no same-cycle pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if (clr) begin
            ovf_q <= 1'b0;
        end else if (push_c && full_c && !pop_c) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;

    ev_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .flush_i (clr),
        .push_i  (push_c),
        .data_i  (rec_c),
        .pop_i   (ev.ready),
        .data_o  (ev.data),
        .valid_o (ev.valid),
        .full_c  (full_c),
        .level_o (level)
    );

endmodule

// File: tb/tb_count_event_logger.sv
// Directed bench for count_event_logger with hand-computed records.
module tb_count_event_logger;

    logic       clk;
    logic       rst;
    logic [2:0] q_in;
    logic       q_en;
    logic       clr;
    logic       ovf;
    logic [2:0] level;

    int n_chk;
    int n_fail;

    count_event_logger_if #(.DATA_W(13)) ev_if ();

    count_event_logger #(
        .WRAP_W (8),
        .DEPTH  (4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .q_in  (q_in),
        .q_en  (q_en),
        .clr   (clr),
        .ev    (ev_if),
        .ovf   (ovf),
        .level (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record encodings {type, wraps, q}
    function automatic logic [31:0] rec(input logic [1:0] t, input logic [7:0] w, input logic [2:0] q);
        return {19'd0, t, w, q};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the edge
    task automatic cyc(input logic en, input logic [2:0] q, input logic c);
        q_en = en;
        q_in = q;
        clr  = c;
        @(posedge clk);
        #1;
        q_en = 1'b0;
        clr  = 1'b0;
    endtask

    logic [31:0] held;

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        rst         = 1'b0;
        q_in        = '0;
        q_en        = 1'b0;
        clr         = 1'b0;
        ev_if.ready = 1'b0;

        // Reset state
        #3;
        check("rst_valid", 32'(ev_if.valid), 32'd0);
        check("rst_data",  32'(ev_if.data),  32'd0);
        check("rst_level", 32'(level),       32'd0);
        check("rst_ovf",   32'(ovf),         32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Clean run 0..7,0,1: exactly one WRAP record, valid for one cycle
        ev_if.ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 3'(i % 8), 1'b0);
            check($sformatf("clean_valid_%0d", i), 32'(ev_if.valid), (i == 8) ? 32'd1 : 32'd0);
            if (i == 8) check("clean_rec", 32'(ev_if.data), rec(2'b01, 8'd1, 3'd0));
        end
        check("clean_ovf", 32'(ovf), 32'd0);

        // Jump: clear, then 2,3,6
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b1, 3'd2, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        check("jump_none_yet", 32'(ev_if.valid), 32'd0);
        cyc(1'b1, 3'd6, 1'b0);
        check("jump_valid", 32'(ev_if.valid), 32'd1);
        check("jump_rec",   32'(ev_if.data),  rec(2'b10, 8'd0, 3'd6));
        cyc(1'b0, 3'd0, 1'b0);
        check("jump_drained", 32'(ev_if.valid), 32'd0);

        // Backpressure and overflow: 5 WRAPs with consumer stalled
        ev_if.ready = 1'b0;
        cyc(1'b0, 3'd0, 1'b1);
        cyc(1'b1, 3'd7, 1'b0);
        cyc(1'b1, 3'd0, 1'b0);
        check("bp_first", 32'(ev_if.data), rec(2'b01, 8'd1, 3'd0));
        held = 32'(ev_if.data);
        for (int w = 2; w <= 5; w++) begin
            for (int s = 1; s <= 8; s++) begin
                cyc(1'b1, 3'(s % 8), 1'b0);
                check("bp_stable", 32'(ev_if.data), held);
            end
            if (w == 4) begin
                check("bp_full_level", 32'(level), 32'd4);
                check("bp_no_ovf_yet", 32'(ovf),   32'd0);
            end
        end
        check("bp_level", 32'(level), 32'd4);
        check("bp_ovf",   32'(ovf),   32'd1);
        ev_if.ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            check($sformatf("bp_drain_%0d", w), 32'(ev_if.data), rec(2'b01, 8'(w), 3'd0));
            cyc(1'b0, 3'd0, 1'b0);
        end
        check("bp_empty_valid", 32'(ev_if.valid), 32'd0);
        check("bp_empty_level", 32'(level),       32'd0);
        check("bp_ovf_sticky",  32'(ovf),         32'd1);

        // Full with simultaneous push and pop
        ev_if.ready = 1'b0;
        cyc(1'b0, 3'd0, 1'b1);
        check("fp_ovf_cleared", 32'(ovf), 32'd0);
        cyc(1'b1, 3'd0, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        cyc(1'b1, 3'd0, 1'b0);
        cyc(1'b1, 3'd3, 1'b0);
        cyc(1'b1, 3'd0, 1'b0);
        check("fp_full", 32'(level), 32'd4);
        ev_if.ready = 1'b1;
        cyc(1'b1, 3'd5, 1'b0);
        check("fp_level", 32'(level), 32'd4);
        check("fp_ovf",   32'(ovf),   32'd0);
        check("fp_d0", 32'(ev_if.data), rec(2'b10, 8'd0, 3'd0));
        cyc(1'b0, 3'd0, 1'b0);
        check("fp_d1", 32'(ev_if.data), rec(2'b10, 8'd0, 3'd3));
        cyc(1'b0, 3'd0, 1'b0);
        check("fp_d2", 32'(ev_if.data), rec(2'b10, 8'd0, 3'd0));
        cyc(1'b0, 3'd0, 1'b0);
        check("fp_d3", 32'(ev_if.data), rec(2'b10, 8'd0, 3'd5));
        cyc(1'b0, 3'd0, 1'b0);
        check("fp_empty", 32'(ev_if.valid), 32'd0);

        // Clear priority over a same-cycle sample
        ev_if.ready = 1'b0;
        cyc(1'b1, 3'd1, 1'b0);
        cyc(1'b1, 3'd4, 1'b0);
        check("clr_two", 32'(level), 32'd2);
        cyc(1'b1, 3'd5, 1'b1);
        check("clr_valid", 32'(ev_if.valid), 32'd0);
        check("clr_level", 32'(level),       32'd0);
        check("clr_ovf",   32'(ovf),         32'd0);
        cyc(1'b1, 3'd7, 1'b0);
        check("clr_init_valid", 32'(ev_if.valid), 32'd0);
        check("clr_init_level", 32'(level),       32'd0);

        // Asynchronous reset mid-stall
        cyc(1'b1, 3'd0, 1'b0);
        check("ar_valid_before", 32'(ev_if.valid), 32'd1);
        check("ar_rec_before",   32'(ev_if.data),  rec(2'b01, 8'd1, 3'd0));
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 32'(ev_if.valid), 32'd0);
        check("ar_data",  32'(ev_if.data),  32'd0);
        check("ar_level", 32'(level),       32'd0);
        check("ar_ovf",   32'(ovf),         32'd0);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
        ev_if.ready = 1'b1;
        cyc(1'b1, 3'd7, 1'b0);
        cyc(1'b1, 3'd0, 1'b0);
        check("ar_restart", 32'(ev_if.data), rec(2'b01, 8'd1, 3'd0));
        check("ar_restart_valid", 32'(ev_if.valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
